lpif_dstrm_arb: RTL
===================

# lpif_dstrm_arb

Downstream arbiter for the x16 LPIF datapath. It shares the single LPIF downstream channel between up to four protocol-stack requesters, each of which owns one protid. Arbitration is round-robin at packet granularity, and the output is a registered valid/ready stage. Its outputs drive the dstrm_* inputs of the lpif_txrx packing block, which fills txfifo_downstream_data.

## Interface
- NUM_REQ, 2: number of requesters, 2..4; requester i is protid i.
- DATA_W, 1024: flit data width in bits.
- BV_W, DATA_W/8: byte-valid width.
- BS_W, $clog2(BV_W): bstart width.
- clk_wr  in  1  single clock for the block.
- rst_wr_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester has a flit.
- req_ready  out  NUM_REQ  flit accepted this cycle.
- req_last  in  NUM_REQ  flit is the last flit of its packet.
- req_data  in  NUM_REQ*DATA_W  flit data, packed with requester i at [i*DATA_W +: DATA_W].
- req_bstart  in  NUM_REQ*BS_W  start byte, packed the same way.
- req_bvalid  in  NUM_REQ*BV_W  byte valids, packed the same way.
- lp_state  in  4  link state request from the link-state controller.
- dstrm_state  out  4  registered copy of lp_state.
- dstrm_protid  out  2  protid of the current flit.
- dstrm_data  out  DATA_W  flit data.
- dstrm_bstart  out  BS_W  flit start byte.
- dstrm_bvalid  out  BV_W  flit byte valids.
- dstrm_valid  out  1  output flit valid.
- dstrm_ready  in  1  downstream (txfifo) can accept a flit.
- arb_locked  out  1  arbiter is in the middle of a packet.

## Operation
- Load enable: load = !dstrm_valid || dstrm_ready.
- Transfer on a requester: req_valid[i] && req_ready[i].
- Transfer on the output: dstrm_valid && dstrm_ready.
- FSM with two states, IDLE and LOCKED.
  - IDLE: grant goes to the first valid requester at or after rr_ptr, in circular order.
  - IDLE -> LOCKED: a granted transfer with req_last=0. The grant index is saved in lock_idx.
  - IDLE, granted transfer with req_last=1: stay in IDLE (single-flit packet).
  - LOCKED: grant is lock_idx only. Other requesters get req_ready=0 even when the output is free.
  - LOCKED -> IDLE: a transfer from lock_idx with req_last=1.
- req_ready[i] = load && grant[i]. At most one bit is set in any cycle.
- rr_ptr update: on every transfer with req_last=1, rr_ptr <= (granted index + 1) mod NUM_REQ. No other event moves rr_ptr.
- On a transfer, the output register loads the granted requester's data, bstart and bvalid, sets dstrm_protid to the grant index, and sets dstrm_valid=1.
- When load=1 and no transfer occurs, dstrm_valid <= 0 and the payload registers hold their value.
- A requester in LOCKED that drops req_valid leaves a bubble. The lock is held and no other requester is served.
- dstrm_state <= lp_state every cycle, independent of handshakes.
- Reset values: all outputs 0, state IDLE, rr_ptr 0, lock_idx 0.

## Timing
- Latency: one cycle from a requester transfer to dstrm_valid.
- Throughput: one flit per cycle while dstrm_ready=1.
- Backpressure: with dstrm_valid=1 and dstrm_ready=0, all dstrm_* outputs except dstrm_state hold stable and req_ready is all zero.
- Output drain and new load in the same cycle are supported. With dstrm_ready=1, the register refills in the cycle it empties, so there are no bubbles.
- Asynchronous reset in the middle of a packet:
  - dstrm_valid clears immediately and the FSM returns to IDLE.
  - A partial packet is not replayed; the requester restarts it after reset.
- Simultaneous requests in IDLE are resolved by rr_ptr alone.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Structure
- Shared package lpif_arb_pkg contains:
  - the FSM enum typedef arb_state_e {ARB_IDLE, ARB_LOCKED};
  - the constant LPIF_STATE_W = 4;
  - the constant PROTID_W = 2.
- Sub-module lpif_rr_pick: combinational round-robin picker. Inputs are the req vector and rr_ptr; outputs are a one-hot grant and a binary index. Reusable by the upstream demux credit logic.
- Everything else stays in lpif_dstrm_arb.

## Test plan
- Single packet: requester 0 sends 3 flits with last on flit 3, dstrm_ready=1 → dstrm_valid on cycles 1..3, protid=0, data matches, arb_locked high after flit 1 and low after flit 3.
- Contention: both requesters valid with 2-flit packets and rr_ptr=0 → output order is pkt0(req0), pkt(req1), pkt(req0); flits are never interleaved and rr_ptr reads 1, 0, 1.
- Backpressure: dstrm_ready=0 for 5 cycles mid-packet → dstrm_data/bvalid/bstart/protid stable, req_ready=0, and no flit is lost or duplicated after release.
- Lock hold: requester 1 locked with req_valid dropped for 2 cycles while requester 0 is valid → requester 0 gets req_ready=0 until requester 1's last flit transfers.
- Reset mid-packet: rst_wr_n asserted low after flit 2 of 4 → all outputs 0 that cycle; after release, arb_locked=0, rr_ptr=0, and fresh arbitration starts.
- Full rate with NUM_REQ=4: all requesters valid with single-flit packets and dstrm_ready=1 → protid sequence 0,1,2,3,0 on consecutive cycles, no bubbles; dstrm_state tracks lp_state with 1-cycle delay.

Source files
------------

// File: rtl/lpif_arb_pkg.sv
// Shared definitions for the LPIF downstream arbiter and its helpers.
//   arb_state_e  : packet-lock FSM states
//   LPIF_STATE_W : width of the LPIF link-state field
//   PROTID_W     : width of the protid field on the downstream channel
package lpif_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned LPIF_STATE_W = 4;
    localparam int unsigned PROTID_W     = 2;

endpackage

// File: rtl/lpif_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set bit of i_req at or after i_ptr, searching circularly.
//   i_req   : request vector, one bit per requester
//   i_ptr   : starting index of the search (must be < NUM_REQ)
//   o_grant : one-hot grant, all zero when no request is set
//   o_idx   : binary index of the granted requester (0 when none)
module lpif_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        logic             w_found;
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_j     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Extra bit keeps ptr + k from overflowing before the wrap.
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_j = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_j]) begin
                w_found       = 1'b1;
                o_grant[w_j]  = 1'b1;
                o_idx         = w_j;
            end
        end
    end

endmodule

// File: rtl/lpif_dstrm_arb.sv
// Downstream arbiter for the LPIF datapath.
// Shares one downstream flit channel between NUM_REQ requesters (requester i owns
// protid i). Arbitration is round-robin per packet; once a multi-flit packet starts,
// its owner keeps the channel until its last flit. Output is a registered
// valid/ready stage that refills in the same cycle it drains.
//   clk_wr, rst_wr_n          : clock, asynchronous active-low reset
//   req_valid/ready/last      : per-requester handshake and end-of-packet
//   req_data/bstart/bvalid    : per-requester payload, requester i at slice i
//   lp_state / dstrm_state    : link-state request and its registered copy
//   dstrm_*                   : registered output flit and handshake
//   arb_locked                : a packet is in progress
module lpif_dstrm_arb
    import lpif_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 1024,
    parameter int unsigned BV_W    = DATA_W / 8,
    parameter int unsigned BS_W    = $clog2(BV_W)
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*BS_W-1:0]   req_bstart,
    input  logic [NUM_REQ*BV_W-1:0]   req_bvalid,
    input  logic [LPIF_STATE_W-1:0]   lp_state,
    output logic [LPIF_STATE_W-1:0]   dstrm_state,
    output logic [PROTID_W-1:0]       dstrm_protid,
    output logic [DATA_W-1:0]         dstrm_data,
    output logic [BS_W-1:0]           dstrm_bstart,
    output logic [BV_W-1:0]           dstrm_bvalid,
    output logic                      dstrm_valid,
    input  logic                      dstrm_ready,
    output logic                      arb_locked
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_e r_state, w_state_d;
    logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_d;
    logic [PTR_W-1:0] r_lock_idx, w_lock_idx_d;

    logic                    r_valid;
    logic [PROTID_W-1:0]     r_protid;
    logic [DATA_W-1:0]       r_data;
    logic [BS_W-1:0]         r_bstart;
    logic [BV_W-1:0]         r_bvalid;
    logic [LPIF_STATE_W-1:0] r_lp_state;

    logic               w_load;
    logic               w_xfer;
    logic               w_last;
    logic [NUM_REQ-1:0] w_req_eff;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_pick_ptr;
    logic [PTR_W-1:0]   w_idx;

    assign w_load = !r_valid || dstrm_ready;

    // While locked only the owner is visible to the picker, so a bubble from the
    // owner leaves the channel idle rather than handing it to someone else.
    always_comb begin
        w_req_eff  = req_valid;
        w_pick_ptr = r_rr_ptr;
        if (r_state == ARB_LOCKED) begin
            w_req_eff  = req_valid & (NUM_REQ'(1) << r_lock_idx);
            w_pick_ptr = r_lock_idx;
        end
    end

    lpif_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (PTR_W)
    ) u_pick (
        .i_req   (w_req_eff),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign req_ready = w_load ? w_grant : '0;
    assign w_xfer    = w_load && (|w_grant);
    assign w_last    = req_last[w_idx];

    always_comb begin
        w_state_d    = r_state;
        w_lock_idx_d = r_lock_idx;
        w_rr_ptr_d   = r_rr_ptr;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_xfer && !w_last) begin
                    w_state_d    = ARB_LOCKED;
                    w_lock_idx_d = w_idx;
                end
            end
            ARB_LOCKED: begin
                if (w_xfer && w_last) begin
                    w_state_d = ARB_IDLE;
                end
            end
            default: w_state_d = ARB_IDLE;
        endcase
        if (w_xfer && w_last) begin
            w_rr_ptr_d = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_d;
            r_rr_ptr   <= w_rr_ptr_d;
            r_lock_idx <= w_lock_idx_d;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_valid    <= 1'b0;
            r_protid   <= '0;
            r_data     <= '0;
            r_bstart   <= '0;
            r_bvalid   <= '0;
            r_lp_state <= '0;
        end else begin
            r_lp_state <= lp_state;
            if (w_load) begin
                r_valid <= w_xfer;
            end
            // Payload only moves on a transfer; an empty slot keeps the last flit.
            if (w_xfer) begin
                r_protid <= PROTID_W'(w_idx);
                r_data   <= req_data[w_idx*DATA_W +: DATA_W];
                r_bstart <= req_bstart[w_idx*BS_W +: BS_W];
                r_bvalid <= req_bvalid[w_idx*BV_W +: BV_W];
            end
        end
    end

    assign dstrm_valid  = r_valid;
    assign dstrm_protid = r_protid;
    assign dstrm_data   = r_data;
    assign dstrm_bstart = r_bstart;
    assign dstrm_bvalid = r_bvalid;
    assign dstrm_state  = r_lp_state;
    assign arb_locked   = (r_state == ARB_LOCKED);

endmodule
